// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 64-bit multiplier.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;
  localparam int WIDTH = 64;
  localparam int CNT_W = $clog2(WIDTH);
endpackage

// File: rtl/mult_shift_add.sv
// One radix-2 shift-add iteration: conditional add into the upper half,
// then shift {carry, acc} and the multiplier right by one.
module mult_shift_add #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    // Carry lands in bit 2*WIDTH-1 after the shift.
    acc_nxt    = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
    mplier_nxt = mplier >> 1;
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle MUL/SMULH/UMULH sequencer: sign-magnitude shift-add over one
// shared adder, pipeline stall while busy, registered product and flags.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carryOut
);
  localparam int CW = $clog2(WIDTH);

  mult_state_t state_q, state_d;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand, mplier, mplier_nxt, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod, fix_val;
  logic               neg;

  // -2^63 negates to itself, which is already the correct unsigned magnitude.
  assign mag_a   = (signed_op & a[WIDTH-1]) ? -a : a;
  assign mag_b   = (signed_op & b[WIDTH-1]) ? -b : b;
  assign fix_val = neg ? -acc : acc;

  mult_shift_add #(.WIDTH(WIDTH)) u_sa (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mplier_nxt (mplier_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = start;
      RUN,
      FIX:     begin busy = 1'b1; stall = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      prod     <= '0;
      zero     <= 1'b1;
      negative <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand  <= mag_a;
          mplier <= mag_b;
          neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc    <= '0;
          count  <= '0;
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          count  <= count + CW'(1);
        end
        // Flags are captured with the product so they hold until the next FIX.
        FIX: begin
          prod     <= fix_val;
          zero     <= (fix_val[WIDTH-1:0] == '0);
          negative <= fix_val[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  assign product_lo = prod[WIDTH-1:0];
  assign product_hi = prod[2*WIDTH-1:WIDTH];
  assign overflow   = 1'b0;
  assign carryOut   = 1'b0;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed vector table, random
// operands against a plain-arithmetic model, ignored-start and reset sequences.
module tb_mult_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, signed_op;
  logic [63:0] a, b;
  logic        busy, done, stall, zero, negative, overflow, carryOut;
  logic [63:0] product_lo, product_hi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .signed_op  (signed_op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .product_lo (product_lo),
    .product_hi (product_hi),
    .zero       (zero),
    .negative   (negative),
    .overflow   (overflow),
    .carryOut   (carryOut)
  );

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic         s;
    logic [127:0] p;
    string        nm;
  } vec_t;

  function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic signed [127:0] sx, sy;
    if (s) begin
      sx = {{64{x[63]}}, x};
      sy = {{64{y[63]}}, y};
      return sx * sy;
    end
    return {64'd0, x} * {64'd0, y};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Runs one multiply; optionally pulses start with junk operands so it is
  // sampled at edges inj1/inj2 (0 = none). Covers 68 cycles after acceptance.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                        input logic [127:0] exp, input int inj1, input int inj2, input string nm);
    int stalls, first_done, ndone;
    logic [127:0] got;
    logic gz, gn, ovf_seen;
    stalls = 0; first_done = -1; ndone = 0; got = '0; gz = 1'b0; gn = 1'b0; ovf_seen = 1'b0;
    @(negedge clk);
    a = ta; b = tb; signed_op = ts; start = 1'b1;
    #1;
    if (stall) stalls++;
    @(posedge clk);
    for (int n = 0; n < 68; n++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (overflow | carryOut) ovf_seen = 1'b1;
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = n; got = {product_hi, product_lo}; gz = zero; gn = negative;
        end
      end
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      signed_op = $urandom_range(0, 1);
      start = (n + 1 == inj1 || n + 1 == inj2);
    end
    chk({nm, ".product"}, got, exp);
    chk({nm, ".zero"}, 128'(gz), 128'(exp[63:0] == 64'd0));
    chk({nm, ".negative"}, 128'(gn), 128'(exp[63]));
    chk({nm, ".done_cycle"}, 128'(first_done), 128'(65));
    chk({nm, ".done_pulses"}, 128'(ndone), 128'(1));
    chk({nm, ".stall_cycles"}, 128'(stalls), 128'(66));
    chk({nm, ".ovf_carry"}, 128'(ovf_seen), 128'(0));
    chk({nm, ".hold"}, {product_hi, product_lo}, exp);
  endtask

  vec_t vecs[6];

  initial begin
    logic [63:0] ra, rb;
    logic        rs;

    vecs[0] = '{64'd3, 64'd5, 1'b0, 128'd15, "u3x5"};
    vecs[1] = '{-64'sd2, 64'd3, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA}, "sm2x3"};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                {64'hFFFF_FFFF_FFFF_FFFE, 64'd1}, "umax"};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                {64'h4000_0000_0000_0000, 64'd0}, "smin"};
    vecs[4] = '{64'd0, 64'h1234, 1'b0, 128'd0, "zero_op"};
    vecs[5] = '{64'd7, -64'sd6, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFD6}, "s7xm6"};

    reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 128'(busy), 128'(0));
    chk("reset.done", 128'(done), 128'(0));
    chk("reset.stall", 128'(stall), 128'(0));
    chk("reset.zero", 128'(zero), 128'(1));
    chk("reset.neg", 128'(negative), 128'(0));
    chk("reset.product", {product_hi, product_lo}, 128'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, 0, 0, vecs[i].nm);

    // start pulses during RUN and FIX must not disturb the result
    run_op(64'd3, 64'd5, 1'b0, 128'd15, 10, 65, "ignored_start");

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
        1: begin ra = 64'($urandom_range(0, 255)); rb = 64'($urandom_range(0, 255)); end
        2: begin ra = {1'b1, 63'($urandom)}; rb = {$urandom, $urandom}; end
        default: begin ra = -64'($urandom_range(1, 1000)); rb = 64'($urandom_range(0, 1000)); end
      endcase
      rs = $urandom_range(0, 1);
      run_op(ra, rb, rs, model(ra, rb, rs), 0, 0, "random");
    end

    // reset in the middle of RUN
    @(negedge clk);
    a = 64'd3; b = 64'd5; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst.busy", 128'(busy), 128'(0));
    chk("midrst.done", 128'(done), 128'(0));
    chk("midrst.stall", 128'(stall), 128'(0));
    chk("midrst.zero", 128'(zero), 128'(1));
    chk("midrst.neg", 128'(negative), 128'(0));
    chk("midrst.product", {product_hi, product_lo}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(64'd7, 64'd6, 1'b0, 128'd42, 0, 0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Multi-cycle sequencer for 64-bit integer multiply (MUL/SMULH/UMULH) in the execute stage. It accepts operands from the ALU operand muxes and runs a radix-2 shift-add loop over one shared 64-bit adder. It holds the pipeline with `stall` until the result is ready, then returns a 128-bit product and flags with the same semantics as the ALU result paths.

## Interface
Parameters:
- `WIDTH`, 64, operand width; product is 2*WIDTH.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `signed_op`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `a`, `b`  in  WIDTH  operands; sampled with `start`.
- `busy`  out  1  high in RUN and FIX.
- `done`  out  1  one-cycle pulse; results valid.
- `stall`  out  1  `busy | (start & state==IDLE)`; holds IF/ID/EX registers.
- `product_lo`, `product_hi`  out  WIDTH  low and high halves of the result.
- `zero`  out  1  `product_lo == 0`.
- `negative`  out  1  `product_lo[WIDTH-1]`.
- `overflow`, `carryOut`  out  1  always 0.

## Operation
- **States:** IDLE, RUN, FIX, DONE.
- **IDLE:**
  - If `start` is high: latch `|a|` and `|b|` as magnitudes; negate an operand only when `signed_op` is set and its MSB is 1.
  - Latch `neg = signed_op & (a[MSB] ^ b[MSB])`.
  - Clear the 128-bit accumulator and set `count = 0`. Go to RUN.
- **RUN:** one iteration per cycle.
  - If multiplier bit 0 is 1, add the multiplicand into acc[127:64] with the carry captured.
  - Shift {carry, acc} right by 1 and shift the multiplier right by 1.
  - `count++`. After the iteration with `count == WIDTH-1`, go to FIX.
- **FIX:** if `neg`, set the product register to two's-complement negate(acc) over 128 bits; otherwise copy acc. Go to DONE.
- **DONE:** assert `done` and drive flags from `product_lo`. Go to IDLE.
- **Result hold:** product, `zero` and `negative` hold their values until the next FIX. Flags are registered, not recomputed from live inputs.
- **`start` outside IDLE** (RUN/FIX/DONE): ignored. No queueing and no restart.
- **Operands:** `a` and `b` may change after the start cycle without effect.
- **Magnitude of −2^63:** 0x8000_0000_0000_0000, treated as an unsigned magnitude. The product stays exact: 2^126 fits in 128 bits.
- **Reset** (asynchronous, any state, including mid-RUN):
  - State goes to IDLE, `count = 0`, accumulator and product = 0.
  - `busy`, `done` and `stall` go to 0; `zero` goes to 1; `negative`, `overflow` and `carryOut` go to 0.
  - No partial result is ever flagged `done`.

## Timing
- **Edge numbering:** edge 0 is the rising edge at which `start` is sampled in IDLE.
- **Stall before acceptance:** `stall` is high combinationally in that same cycle, before the edge.
- **Sequence:**
  - Edges 1–64: RUN iterations.
  - Edge 65: FIX → DONE; product registered.
  - `done` is high between edges 65 and 66.
  - Edge 66: back to IDLE.
- **Latency:** 66 cycles from start acceptance to the `done` cycle.
- **Stall release:** `stall` is low in the DONE cycle, so the EX/MEM register captures the product at edge 66.
- **Back-to-back:** the earliest next accept is edge 66 if `start` is high in DONE? No. `start` is ignored in DONE, so the earliest next accept is edge 67. Restart spacing is 67 cycles.
- **Arithmetic:** the adder is WIDTH+1 bits (carry kept); the negate is 128-bit.

## Structure
- **Package `mult_pkg`:**
  - `typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t`
  - `localparam WIDTH = 64`
  - `localparam CNT_W = $clog2(WIDTH)`
- **Sub-module `mult_shift_add`:** the per-iteration datapath (conditional add, carry, right shift of acc and multiplier). Purely combinational, one instance.
- **Top:** `mult_seq_ctrl` holds the FSM, counter, sign logic, FIX negate and flag registers.

## Test plan
- **Unsigned, small:** `a=3`, `b=5`, `signed_op=0` → after 66 cycles `product_lo=15`, `product_hi=0`, `zero=0`, `negative=0`; `done` is high for exactly 1 cycle; `stall` is high for 66 cycles.
- **Signed, mixed signs:** `a=-2`, `b=3`, `signed_op=1` → `product_lo=0xFFFF_FFFF_FFFF_FFFA`, `product_hi=0xFFFF_FFFF_FFFF_FFFF`, `negative=1`.
- **Width extremes:**
  - Unsigned `a=b=0xFFFF_FFFF_FFFF_FFFF` → `product_hi=0xFFFF_FFFF_FFFF_FFFE`, `product_lo=1`.
  - Signed `a=b=0x8000_0000_0000_0000` → `product_hi=0x4000_0000_0000_0000`, `product_lo=0`, `zero=1`.
- **Zero operand:** `a=0`, `b=0x1234` → `product=0`, `zero=1`, `negative=0`. `overflow` and `carryOut` stay 0 throughout.
- **Ignored start:** pulse `start` with new operands at edges 10 and 65 → ignored. The result equals the first operation, and `done` fires only once.
- **Reset mid-operation:** assert `reset_n=0` at cycle 30 of RUN → outputs are immediately at reset values and no `done` pulse occurs. After release, a new `start` with `7*6` yields 42 with normal 66-cycle latency.
